// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
// Shared definitions for the ROM port arbiter slice: default ROM geometry,
// the starvation-guard default and the arbiter FSM state type.
// No ports (package).

package rom_arb_pkg;

    // 1024-word x 32-bit instruction ROM.
    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 32;

    // Consecutive denied cycles of the fetch port before it is forced through.
    localparam int DEFAULT_MAX_WAIT = 3;

    // Wide enough for the largest legal MAX_WAIT (15).
    localparam int WAIT_CNT_W = 4;

    // D_PRIO  : data port wins a conflict.
    // I_FORCE : fetch port wins the next cycle it requests.
    typedef enum logic [0:0] {
        D_PRIO  = 1'b0,
        I_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rom_arb_resp_reg.sv
// rom_arb_resp_reg
// Per-port response register. When the port was granted this cycle, the ROM
// word is captured on the next edge and rvalid pulses for one cycle. Without
// a grant the read data holds its last value.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   capture  in   port granted this cycle
//   din      in   combinational ROM read data
//   rvalid   out  response valid (one cycle after the grant)
//   rdata    out  registered read data

module rom_arb_resp_reg
    import rom_arb_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] din,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // Capture on grant; the valid flag simply follows the grant by one cycle,
    // which gives full throughput on back-to-back grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= din;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one combinational-read ROM between the instruction-fetch port (i_*)
// and a data-load port (d_*). One access per cycle, registered read data one
// cycle after the grant. The data port normally wins a conflict; after
// MAX_WAIT consecutive denied cycles the fetch port is forced through.
// Optional build macro: ROM_ARB_PERF_EN adds conflict_cnt and force_cnt.
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   i_req, i_addr                  fetch request and word address
//   i_gnt                          fetch granted this cycle (combinational)
//   i_rvalid, i_rdata              fetch response (registered)
//   d_req, d_addr                  data-read request and word address
//   d_gnt                          data granted this cycle (combinational)
//   d_rvalid, d_rdata              data response (registered)
//   rom_address, rom_data          ROM address out, ROM read data in
//   conflict_cnt (perf build only) saturating count of both-request cycles
//   force_cnt    (perf build only) saturating count of entries into I_FORCE

module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W   = ROM_ADDR_W,
    parameter int DATA_W   = ROM_DATA_W,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [7:0]        force_cnt
`endif
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    arb_state_e            state;
    arb_state_e            state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_next;

    // Grants depend only on the live requests and the current state, so they
    // stay meaningful during reset (state is held at D_PRIO there) and the
    // ROM address is always defined.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (i_req && d_req) begin
            if (state == I_FORCE) begin
                i_gnt = 1'b1;
            end else begin
                d_gnt = 1'b1;
            end
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end
    end

    // Idle cycles present the fetch address to the ROM.
    assign rom_address = d_gnt ? d_addr : i_addr;

    // Starvation guard. The counter tracks consecutive denied fetch cycles;
    // the cycle on which it reaches MAX_WAIT moves us into I_FORCE, so the
    // forced grant lands on the following cycle. I_FORCE lasts one cycle:
    // either the fetch is granted or it has withdrawn, both return to D_PRIO.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            D_PRIO: begin
                if (i_req && !i_gnt) begin
                    if (wait_cnt >= (MAX_WAIT_C - WAIT_CNT_W'(1))) begin
                        wait_next  = MAX_WAIT_C;
                        state_next = I_FORCE;
                    end else begin
                        wait_next = wait_cnt + WAIT_CNT_W'(1);
                    end
                end else begin
                    wait_next = '0;
                end
            end
            I_FORCE: begin
                wait_next  = '0;
                state_next = D_PRIO;
            end
            default: begin
                wait_next  = '0;
                state_next = D_PRIO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= D_PRIO;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    rom_arb_resp_reg #(
        .DATA_W (DATA_W)
    ) u_i_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (i_gnt),
        .din     (rom_data),
        .rvalid  (i_rvalid),
        .rdata   (i_rdata)
    );

    rom_arb_resp_reg #(
        .DATA_W (DATA_W)
    ) u_d_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (d_gnt),
        .din     (rom_data),
        .rvalid  (d_rvalid),
        .rdata   (d_rdata)
    );

`ifdef ROM_ARB_PERF_EN
    // Both counters saturate rather than wrap so a long run never reads low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            force_cnt    <= '0;
        end else begin
            if (i_req && d_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if ((state == D_PRIO) && (state_next == I_FORCE) && (force_cnt != 8'hFF)) begin
                force_cnt <= force_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
// Self-checking bench for rom_port_arbiter: reset checks, a table of grant
// vectors (conflict, starvation, withdrawal in I_FORCE), streaming, reset in
// flight, randomized traffic against a reference model, and the perf
// counters when ROM_ARB_PERF_EN is defined.

module tb_rom_port_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
`ifdef ROM_ARB_PERF_EN
    logic [15:0]       conflict_cnt;
    logic [7:0]        force_cnt;
`endif

    // Behavioural ROM.
    logic [DATA_W-1:0] rom [1024];
    assign rom_data = rom[rom_address];

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .rom_address  (rom_address),
        .rom_data     (rom_data)
`ifdef ROM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: how many consecutive cycles the fetch port has been
    // requesting and losing, plus the expected response registers.
    int                streak = 0;
    logic              exp_i_valid = 1'b0;
    logic              exp_d_valid = 1'b0;
    logic [DATA_W-1:0] exp_i_data = '0;
    logic [DATA_W-1:0] exp_d_data = '0;

    // Grant and address seen on the most recent applyStimulus call.
    logic              seen_i_gnt;
    logic              seen_d_gnt;
    logic [ADDR_W-1:0] seen_rom_addr;

    typedef struct {
        logic              ir;
        logic [ADDR_W-1:0] ia;
        logic              dr;
        logic [ADDR_W-1:0] da;
        logic              gi;
        logic              gd;
        logic [ADDR_W-1:0] ra;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data port wins conflicts unless the fetch port has already lost
    // MAX_WAIT cycles in a row.
    task automatic modelGrant(input logic ir, input logic dr, output logic gi, output logic gd);
        if (ir && dr) begin
            gi = (streak >= MAX_WAIT);
            gd = !gi;
        end else begin
            gi = ir;
            gd = dr;
        end
    endtask

    task automatic modelReset();
        streak      = 0;
        exp_i_valid = 1'b0;
        exp_d_valid = 1'b0;
        exp_i_data  = '0;
        exp_d_data  = '0;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_i_rvalid"}, 32'(i_rvalid), 32'(exp_i_valid));
        checkOutput({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(exp_d_valid));
        checkOutput({tag, "_i_rdata"}, i_rdata, exp_i_data);
        checkOutput({tag, "_d_rdata"}, d_rdata, exp_d_data);
    endtask

    // One clock cycle: drive requests, check combinational grant/address,
    // cross the edge, then check the registered responses.
    task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                 input logic dr, input logic [ADDR_W-1:0] da);
        logic gi;
        logic gd;
        logic [ADDR_W-1:0] ea;
        i_req  = ir;
        i_addr = ia;
        d_req  = dr;
        d_addr = da;
        #1;
        modelGrant(ir, dr, gi, gd);
        ea = gd ? da : ia;
        seen_i_gnt    = i_gnt;
        seen_d_gnt    = d_gnt;
        seen_rom_addr = rom_address;
        checkOutput("i_gnt", 32'(i_gnt), 32'(gi));
        checkOutput("d_gnt", 32'(d_gnt), 32'(gd));
        checkOutput("rom_address", 32'(rom_address), 32'(ea));
        @(posedge clk);
        #1;
        exp_i_valid = gi;
        exp_d_valid = gd;
        if (gi) exp_i_data = rom[ia];
        if (gd) exp_d_data = rom[da];
        if (ir && !gi) begin
            if (streak < MAX_WAIT) streak = streak + 1;
        end else begin
            streak = 0;
        end
        checkRegs("resp");
    endtask

    // Assert reset (asynchronously, mid-cycle) with the given requests,
    // check outputs are cleared while grants still follow the requests,
    // hold across an edge and release.
    task automatic doReset(input logic ir, input logic [ADDR_W-1:0] ia,
                           input logic dr, input logic [ADDR_W-1:0] da);
        logic gi;
        logic gd;
        i_req  = ir;
        i_addr = ia;
        d_req  = dr;
        d_addr = da;
        rst_n  = 1'b0;
        modelReset();
        #1;
        modelGrant(ir, dr, gi, gd);
        checkOutput("rst_i_gnt", 32'(i_gnt), 32'(gi));
        checkOutput("rst_d_gnt", 32'(d_gnt), 32'(gd));
        checkOutput("rst_rom_address", 32'(rom_address), 32'(gd ? da : ia));
        checkRegs("rst");
        @(posedge clk);
        #1;
        checkRegs("rst_edge");
        rst_n = 1'b1;
    endtask

    initial begin
        int stream_valid;

        vecs[0]  = '{1'b1, 10'd1, 1'b0, 10'd0,  1'b1, 1'b0, 10'd1};
        vecs[1]  = '{1'b1, 10'd2, 1'b1, 10'd7,  1'b0, 1'b1, 10'd7};
        vecs[2]  = '{1'b0, 10'd3, 1'b0, 10'd0,  1'b0, 1'b0, 10'd3};
        vecs[3]  = '{1'b1, 10'd4, 1'b1, 10'd9,  1'b0, 1'b1, 10'd9};
        vecs[4]  = '{1'b1, 10'd4, 1'b1, 10'd9,  1'b0, 1'b1, 10'd9};
        vecs[5]  = '{1'b1, 10'd4, 1'b1, 10'd9,  1'b0, 1'b1, 10'd9};
        vecs[6]  = '{1'b1, 10'd4, 1'b1, 10'd9,  1'b1, 1'b0, 10'd4};
        vecs[7]  = '{1'b1, 10'd4, 1'b1, 10'd9,  1'b0, 1'b1, 10'd9};
        vecs[8]  = '{1'b0, 10'd4, 1'b1, 10'd12, 1'b0, 1'b1, 10'd12};
        vecs[9]  = '{1'b1, 10'd5, 1'b0, 10'd0,  1'b1, 1'b0, 10'd5};
        vecs[10] = '{1'b1, 10'd6, 1'b1, 10'd13, 1'b0, 1'b1, 10'd13};
        vecs[11] = '{1'b1, 10'd6, 1'b1, 10'd13, 1'b0, 1'b1, 10'd13};
        vecs[12] = '{1'b1, 10'd6, 1'b1, 10'd13, 1'b0, 1'b1, 10'd13};
        vecs[13] = '{1'b0, 10'd6, 1'b1, 10'd13, 1'b0, 1'b1, 10'd13};
        vecs[14] = '{1'b1, 10'd6, 1'b1, 10'd13, 1'b0, 1'b1, 10'd13};
        vecs[15] = '{1'b0, 10'd0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd0};

        for (int a = 0; a < 1024; a++) begin
            rom[a] = $urandom;
        end

        // Reset held with both requesting, then a fetch at address 5.
        @(posedge clk);
        #1;
        doReset(1'b1, 10'd3, 1'b1, 10'd8);
        applyStimulus(1'b1, 10'd5, 1'b0, 10'd0);
        checkOutput("first_fetch_data", i_rdata, rom[5]);

        // Directed grant vectors including starvation and withdrawal in I_FORCE.
        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].da);
            checkOutput($sformatf("vec%0d_i_gnt", v), 32'(seen_i_gnt), 32'(vecs[v].gi));
            checkOutput($sformatf("vec%0d_d_gnt", v), 32'(seen_d_gnt), 32'(vecs[v].gd));
            checkOutput($sformatf("vec%0d_rom_addr", v), 32'(seen_rom_addr), 32'(vecs[v].ra));
        end

        // Streaming fetches at addresses 0..7.
        stream_valid = 0;
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, ADDR_W'(a), 1'b0, 10'd0);
            if (i_rvalid === 1'b1) stream_valid++;
            checkOutput($sformatf("stream_data%0d", a), i_rdata, rom[a]);
        end
        checkOutput("stream_len", 32'(stream_valid), 32'd8);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

        // Reset while a response is pending and another grant is in flight.
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd20);
        doReset(1'b1, 10'd21, 1'b0, 10'd0);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, ADDR_W'($urandom),
                          $urandom_range(0, 3) != 0, ADDR_W'($urandom));
        end

`ifdef ROM_ARB_PERF_EN
        doReset(1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("perf_conflict_reset", 32'(conflict_cnt), 32'd0);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, 10'd4, 1'b1, 10'd9);
        end
        checkOutput("perf_conflict_cnt", 32'(conflict_cnt), 32'd20);
        checkOutput("perf_force_cnt", 32'(force_cnt), 32'd5);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("perf_conflict_cleared", 32'(conflict_cnt), 32'd0);
        checkOutput("perf_force_cleared", 32'(force_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
Shares the single combinational-read instruction ROM between two requesters: the instruction-fetch port (I) and a data-load port (D), for constant tables and debug reads. It sits between the fetch stage, the load/store unit and the ROM. It arbitrates one access per cycle and returns registered read data with a fixed 1-cycle latency. D normally has priority, and a starvation guard forces I through after a bounded wait.

Parameters:
ADDR_W, 10, ROM word-address width; matches the 1024-word ROM.
DATA_W, 32, ROM word width.
MAX_WAIT, 3, consecutive denied cycles of I before I is forced to win; legal range 1..15.

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
I_REQ  in  1  fetch request; held with I_ADDR stable until I_GNT.
I_ADDR  in  ADDR_W  fetch word address.
I_GNT  out  1  fetch granted this cycle (combinational).
I_RVALID  out  1  fetch data valid, one cycle after grant.
I_RDATA  out  DATA_W  fetch read data (registered).
D_REQ  in  1  data-read request; held with D_ADDR stable until D_GNT.
D_ADDR  in  ADDR_W  data word address.
D_GNT  out  1  data granted this cycle (combinational).
D_RVALID  out  1  data valid, one cycle after grant.
D_RDATA  out  DATA_W  data read data (registered).
ROM_ADDRESS  out  ADDR_W  address to the ROM.
ROM_DATA  in  DATA_W  combinational ROM read data.

Behaviour:
- Clocking and reset: one clock, CLK; reset is asynchronous, active-low, on RESET_N.
- Outputs held during reset: I_RVALID=0, D_RVALID=0, I_RDATA=0, D_RDATA=0, wait_cnt=0, FSM=D_PRIO.
- I_GNT and D_GNT follow the current REQ inputs even during reset, because ROM_ADDRESS must stay defined.
- Grant rules:
  - At most one grant per cycle; I_GNT and D_GNT are never both 1.
  - Only-I or only-D request: that port is granted.
  - Both requesting in state D_PRIO: D is granted.
  - Both requesting in state I_FORCE: I is granted.
- ROM_ADDRESS = D_ADDR when D_GNT=1, otherwise I_ADDR (this includes the idle case).
- Response path:
  - On the edge after a grant, ROM_DATA is captured into the granted port's RDATA register and that port's RVALID=1 for exactly one cycle.
  - The non-granted port's RDATA register holds its previous value.
  - Back-to-back grants to the same port give RVALID=1 on consecutive cycles (full throughput).
- FSM, 2 states:
  - D_PRIO: wait_cnt increments (saturating at MAX_WAIT) on every cycle I_REQ=1 and I_GNT=0; wait_cnt clears on I_GNT or on I_REQ=0. When wait_cnt reaches MAX_WAIT, next state is I_FORCE.
  - I_FORCE: I is granted the next cycle it requests; the FSM then returns to D_PRIO with wait_cnt=0. If I drops I_REQ while in I_FORCE, the FSM returns to D_PRIO without a grant.
- Worst-case I latency under continuous D traffic: MAX_WAIT denied cycles, then a grant on the following cycle.
- Requester protocol violations (changing ADDR or dropping REQ before GNT) are not checked. The arbiter re-evaluates every cycle.
- Reset mid-operation: any pending RVALID is dropped and no response is delivered for the grant in flight.
- No address range checking; the address width is the ROM's.

Optional Feature:
Macro ROM_ARB_PERF_EN.
- Defined:
  - Adds output CONFLICT_CNT (16 bits): saturating count of cycles with I_REQ=1 and D_REQ=1. Reset to 0. Holds at 16'hFFFF.
  - Adds output FORCE_CNT (8 bits): saturating count of entries into I_FORCE.
- Not defined: neither port nor the counter logic exists; the rest of the behaviour is identical.

Decomposition:
- Shared package rom_arb_pkg: FSM state typedef (D_PRIO, I_FORCE), default ROM widths, MAX_WAIT default.
- One natural sub-module, rom_arb_resp_reg: per-port response register (capture enable, RVALID pulse, RDATA hold). Instantiated twice.
- Grant logic and FSM stay in the top.

Test Plan:
- Reset: hold RESET_N=0 with both requests asserted -> both RVALID=0, both RDATA=0; first edge after release with I_REQ only at I_ADDR=5 -> I_RVALID=1 with I_RDATA=ROM[5].
- Single fetch: I_REQ=1, I_ADDR=10'h001, D idle -> I_GNT=1 same cycle; I_RVALID=1 next cycle, with I_RDATA=ROM[1]; D_RVALID stays 0.
- Conflict: both request, I_ADDR=2, D_ADDR=7, state D_PRIO -> D_GNT=1, ROM_ADDRESS=7; D_RDATA=ROM[7] next cycle; I_GNT=0.
- Starvation, MAX_WAIT=3: D_REQ held high continuously with I_REQ=1 -> I denied 3 cycles, I_GNT=1 on cycle 4 and D_GNT=0 that cycle; D granted again on cycle 5.
- Streaming: I_REQ high for 8 cycles with addresses 0..7 -> I_RVALID high for 8 consecutive cycles with data ROM[0..7] in order.
- With ROM_ARB_PERF_EN defined: 20 cycles of simultaneous requests -> CONFLICT_CNT=20 and FORCE_CNT=5 (MAX_WAIT=3); assert RESET_N=0 mid-run -> both counters read 0.
